// File: rtl/halt_dump_tx.sv
// halt_dump_tx
// -----------------------------------------------------------------------------
// Post-halt state transmitter. When the CPU halted flag rises, this block
// snapshots the eight CPU registers. It then reads a window of RAM and streams
// a framed byte sequence over a valid/ready interface:
//   HEADER, A, B, C, D, E, F, G, T, RAM[base .. base+len-1], CHK
// CHK is the mod-256 sum of every byte between the header and CHK.
//
// Parameters:
//   DUMP_BASE  first RAM address dumped (the address wraps modulo 256)
//   DUMP_LEN   number of RAM bytes dumped, 1..256
//   HEADER     frame start byte
//
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   halted              CPU halted flag (level)
//   rega .. regt        CPU register values
//   mem_addr, mem_rd    RAM read address and read strobe
//   mem_data            RAM read data, valid the cycle after mem_rd
//   out_data, out_valid stream byte and its valid flag (registered)
//   out_ready           sink accepts the byte
//   busy, done          frame in progress / frame complete
// -----------------------------------------------------------------------------
module halt_dump_tx #(
  parameter logic [7:0]  DUMP_BASE = 8'h00,
  parameter int unsigned DUMP_LEN  = 16,
  parameter logic [7:0]  HEADER    = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       halted,
  input  logic [7:0] rega,
  input  logic [7:0] regb,
  input  logic [7:0] regc,
  input  logic [7:0] regd,
  input  logic [7:0] rege,
  input  logic [7:0] regf,
  input  logic [7:0] regg,
  input  logic [7:0] regt,
  output logic [7:0] mem_addr,
  output logic       mem_rd,
  input  logic [7:0] mem_data,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_REGS, S_MEM_REQ, S_MEM_WAIT, S_MEM_SEND, S_CSUM, S_DONE
  } state_t;

  // Nine bits so that a 256-byte window compares correctly against the count.
  localparam logic [8:0] LEN9 = 9'(DUMP_LEN);

  state_t          state_q, state_d;
  logic            halted_q;
  logic [7:0][7:0] regs_in;
  logic [7:0][7:0] snap_q, snap_d;
  logic [2:0]      idx_q, idx_d;
  logic [8:0]      cnt_q, cnt_d;
  logic [7:0]      addr_q, addr_d;
  logic [7:0]      data_q, data_d;
  logic [7:0]      sum_q, sum_d;
  logic            valid_q, valid_d;
  logic            trigger;
  logic            accept;
  logic [7:0]      next_addr;

  assign regs_in   = {regt, regg, regf, rege, regd, regc, regb, rega};
  assign trigger   = halted && !halted_q && (state_q == S_IDLE);
  assign accept    = valid_q && out_ready;
  // cnt_q counts RAM bytes already requested, so it is also the next offset.
  assign next_addr = DUMP_BASE + cnt_q[7:0];

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Once a frame starts it runs to completion; halted is
  // only consulted again in DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (trigger) state_d = S_HDR;
      S_HDR:      if (accept) state_d = S_REGS;
      S_REGS:     if (accept && idx_q == 3'd7) state_d = S_MEM_REQ;
      S_MEM_REQ:  state_d = S_MEM_WAIT;
      S_MEM_WAIT: state_d = S_MEM_SEND;
      S_MEM_SEND: if (accept) state_d = (cnt_q == LEN9) ? S_CSUM : S_MEM_REQ;
      S_CSUM:     if (accept) state_d = S_DONE;
      S_DONE:     if (!halted) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Datapath next values. Each byte is loaded into the output register on the
  // same edge that makes it valid, and it is added to the running checksum then.
  // Consecutive bytes (header, registers, checksum) keep valid high across the
  // accept edge, so no idle cycle appears between them.
  always_comb begin
    snap_d  = snap_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    sum_d   = sum_q;
    valid_d = valid_q;
    case (state_q)
      S_IDLE: begin
        if (trigger) begin
          snap_d  = regs_in;
          idx_d   = 3'd0;
          cnt_d   = 9'd0;
          sum_d   = 8'h00;
          data_d  = HEADER;
          valid_d = 1'b1;
        end
      end
      S_HDR: begin
        if (accept) begin
          data_d = snap_q[0];
          sum_d  = sum_q + snap_q[0];
        end
      end
      S_REGS: begin
        if (accept) begin
          if (idx_q == 3'd7) begin
            valid_d = 1'b0;
            addr_d  = next_addr;
            cnt_d   = cnt_q + 9'd1;
          end else begin
            idx_d  = idx_q + 3'd1;
            data_d = snap_q[idx_q + 3'd1];
            sum_d  = sum_q + snap_q[idx_q + 3'd1];
          end
        end
      end
      S_MEM_WAIT: begin
        data_d  = mem_data;
        sum_d   = sum_q + mem_data;
        valid_d = 1'b1;
      end
      S_MEM_SEND: begin
        if (accept) begin
          if (cnt_q == LEN9) begin
            data_d = sum_q;
          end else begin
            valid_d = 1'b0;
            addr_d  = next_addr;
            cnt_d   = cnt_q + 9'd1;
          end
        end
      end
      S_CSUM: begin
        if (accept) valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Datapath registers. An asynchronous reset abandons any frame in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      halted_q <= 1'b0;
      snap_q   <= '0;
      idx_q    <= 3'd0;
      cnt_q    <= 9'd0;
      addr_q   <= DUMP_BASE;
      data_q   <= 8'h00;
      sum_q    <= 8'h00;
      valid_q  <= 1'b0;
    end else begin
      halted_q <= halted;
      snap_q   <= snap_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      sum_q    <= sum_d;
      valid_q  <= valid_d;
    end
  end

  // Outputs decoded from the state register.
  always_comb begin
    mem_rd    = (state_q == S_MEM_REQ);
    busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    done      = (state_q == S_DONE);
    mem_addr  = addr_q;
    out_data  = data_q;
    out_valid = valid_q;
  end

endmodule

// File: tb/tb_halt_dump_tx.sv
// tb_halt_dump_tx
// -----------------------------------------------------------------------------
// Directed testbench for halt_dump_tx. It uses two instances: dut uses the
// default window (base 00, 16 bytes), and dut2 uses a wrapping window
// (base F8, 16 bytes). Both instances share all inputs. A small behavioural
// RAM answers reads one cycle after mem_rd.
// -----------------------------------------------------------------------------
module tb_halt_dump_tx;

  logic       clk = 1'b0;
  logic       reset, halted, out_ready;
  logic [7:0] rega, regb, regc, regd, rege, regf, regg, regt;
  logic [7:0] mem_addr, mem_data, out_data;
  logic       mem_rd, out_valid, busy, done;
  logic [7:0] mem_addr2, mem_data2, out_data2;
  logic       mem_rd2, out_valid2, busy2, done2;

  logic [7:0] ram [256];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         p;
  logic       sawActivity;

  logic [7:0] gotBytes[$];
  int         gotCycles[$];
  logic [7:0] expBytes[$];
  logic [7:0] addrQ2[$];
  int         stallBad, rdBad, stalls;

  halt_dump_tx dut (
    .clk(clk), .reset(reset), .halted(halted),
    .rega(rega), .regb(regb), .regc(regc), .regd(regd),
    .rege(rege), .regf(regf), .regg(regg), .regt(regt),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  halt_dump_tx #(.DUMP_BASE(8'hF8), .DUMP_LEN(16), .HEADER(8'hA5)) dut2 (
    .clk(clk), .reset(reset), .halted(halted),
    .rega(rega), .regb(regb), .regc(regc), .regd(regd),
    .rege(rege), .regf(regf), .regg(regg), .regt(regt),
    .mem_addr(mem_addr2), .mem_rd(mem_rd2), .mem_data(mem_data2),
    .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready),
    .busy(busy2), .done(done2)
  );

  always #5 clk = ~clk;

  // Cycle counter: it holds the number of rising edges seen so far.
  always @(posedge clk) cyc <= cyc + 1;

  // The RAM returns read data on the cycle after the strobe.
  always @(posedge clk) begin
    if (mem_rd)  mem_data  <= ram[mem_addr];
    if (mem_rd2) mem_data2 <= ram[mem_addr2];
  end

  // Record every address that the wrapping instance reads.
  always @(negedge clk) if (mem_rd2) addrQ2.push_back(mem_addr2);

  // Stop a run that hangs, and report it as a failure.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] first);
    rega = first;         regb = first + 8'd1; regc = first + 8'd2; regd = first + 8'd3;
    rege = first + 8'd4;  regf = first + 8'd5; regg = first + 8'd6; regt = first + 8'd7;
  endtask

  // Reference frame built from the current register values and the RAM contents.
  task automatic buildExpected(input logic [7:0] base, input int len);
    logic [7:0] r [8];
    logic [7:0] s;
    logic [7:0] a;
    s = 8'h00;
    r = '{rega, regb, regc, regd, rege, regf, regg, regt};
    expBytes.delete();
    expBytes.push_back(8'hA5);
    foreach (r[i]) begin
      expBytes.push_back(r[i]);
      s = s + r[i];
    end
    for (int k = 0; k < len; k++) begin
      a = base + 8'(k);
      expBytes.push_back(ram[a]);
      s = s + ram[a];
    end
    expBytes.push_back(s);
  endtask

  function automatic logic [31:0] gotByteAt(input int i);
    if (i < gotBytes.size()) return {24'h0, gotBytes[i]};
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] gotCycleAt(input int i);
    if (i < gotCycles.size()) return gotCycles[i];
    return 32'hFFFF_FFFF;
  endfunction

  // Drive out_ready (always high, or random), collect accepted bytes from the
  // selected instance, and track stability on stalled cycles. If dropAfter is
  // nonzero, halted is lowered once that many bytes have been seen.
  task automatic collectFrame(input bit sel, input int nBytes, input bit randomReady,
                              input int dropAfter);
    int         guard;
    logic       prevValid, prevReady, v, rd;
    logic [7:0] prevData, d;
    gotBytes.delete();
    gotCycles.delete();
    stallBad = 0; rdBad = 0; stalls = 0;
    prevValid = 1'b0; prevReady = 1'b1; prevData = 8'h00; guard = 0;
    while (gotBytes.size() < nBytes && guard < 3000) begin
      out_ready = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      v  = sel ? out_valid2 : out_valid;
      d  = sel ? out_data2  : out_data;
      rd = sel ? mem_rd2    : mem_rd;
      if (prevValid && !prevReady) begin
        stalls++;
        if (!v || d !== prevData) stallBad++;
      end
      if (v && rd) rdBad++;
      if (v && out_ready) begin
        gotBytes.push_back(d);
        gotCycles.push_back(cyc);
        if (dropAfter > 0 && gotBytes.size() == dropAfter) halted = 1'b0;
      end
      prevValid = v; prevReady = out_ready; prevData = d;
      @(posedge clk);
      #1;
      guard++;
    end
    out_ready = 1'b1;
    checkOutput("frameLen", gotBytes.size(), nBytes);
  endtask

  task automatic compareFrame(input string tag);
    foreach (expBytes[i])
      checkOutput($sformatf("%s_byte%0d", tag, i), gotByteAt(i), {24'h0, expBytes[i]});
  endtask

  initial begin
    // Reset state
    reset = 1'b1; halted = 1'b0; out_ready = 1'b1; mem_data = 8'h00; mem_data2 = 8'h00;
    applyStimulus(8'h01);
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    ram[0] = 8'd42;
    tick(3);
    checkOutput("rst_valid", out_valid, 1'b0);
    checkOutput("rst_data", out_data, 8'h00);
    checkOutput("rst_memrd", mem_rd, 1'b0);
    checkOutput("rst_addr", mem_addr, 8'h00);
    checkOutput("rst_addr2", mem_addr2, 8'hF8);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    reset = 1'b0;
    sawActivity = 1'b0;
    repeat (20) begin
      tick(1);
      if (out_valid || busy) sawActivity = 1'b1;
    end
    checkOutput("idle_quiet", sawActivity, 1'b0);

    // Basic frame with the default window: A5,01..08,2A,15x00,4E
    $display("[TB] basic frame");
    buildExpected(8'h00, 16);
    p = cyc;
    halted = 1'b1;
    collectFrame(1'b0, 26, 1'b0, 0);
    compareFrame("basic");
    checkOutput("basic_ram0", gotByteAt(9), 8'h2A);
    checkOutput("basic_chk", gotByteAt(25), 8'h4E);
    checkOutput("basic_hdrCycle", gotCycleAt(0), p + 1);
    checkOutput("basic_mem0Cycle", gotCycleAt(9), p + 12);
    checkOutput("basic_chkCycle", gotCycleAt(25), p + 58);
    checkOutput("basic_doneCycle", cyc, p + 59);
    checkOutput("basic_done", done, 1'b1);
    checkOutput("basic_busyLow", busy, 1'b0);
    halted = 1'b0;
    tick(1);
    checkOutput("basic_idleDone", done, 1'b0);
    tick(1);

    // Backpressure: same frame with random ready
    $display("[TB] backpressure");
    buildExpected(8'h00, 16);
    halted = 1'b1;
    collectFrame(1'b0, 26, 1'b1, 0);
    compareFrame("bp");
    checkOutput("bp_chk", gotByteAt(25), 8'h4E);
    checkOutput("bp_stable", stallBad, 0);
    checkOutput("bp_noRdWhilePending", rdBad, 0);
    checkOutput("bp_sawStalls", stalls > 0, 1'b1);
    halted = 1'b0;
    tick(2);

    // Wrapping window on dut2: reads F8..FF then 00..07
    $display("[TB] wrap");
    ram[8'hF8] = 8'hF0;
    addrQ2.delete();
    buildExpected(8'hF8, 16);
    halted = 1'b1;
    collectFrame(1'b1, 26, 1'b0, 0);
    compareFrame("wrap");
    checkOutput("wrap_firstRam", gotByteAt(9), 8'hF0);
    checkOutput("wrap_ram00", gotByteAt(17), 8'h2A);
    checkOutput("wrap_chk", gotByteAt(25), 8'h3E);
    checkOutput("wrap_nAddr", addrQ2.size(), 16);
    for (int k = 0; k < 16; k++) begin
      logic [7:0] ea;
      ea = 8'hF8 + 8'(k);
      checkOutput($sformatf("wrap_addr%0d", k),
                  (k < addrQ2.size()) ? {24'h0, addrQ2[k]} : 32'hFFFF_FFFF, {24'h0, ea});
    end
    halted = 1'b0;
    tick(2);

    // Drop halted after byte 5: the full frame is sent and done pulses once
    $display("[TB] halted dropped mid-frame");
    buildExpected(8'h00, 16);
    halted = 1'b1;
    collectFrame(1'b0, 26, 1'b0, 5);
    compareFrame("drop");
    checkOutput("drop_done", done, 1'b1);
    tick(1);
    checkOutput("drop_donePulse", done, 1'b0);
    checkOutput("drop_idle", busy, 1'b0);
    tick(2);

    // A halted glitch during DONE must not start a new frame
    $display("[TB] glitch in DONE");
    halted = 1'b1;
    collectFrame(1'b0, 26, 1'b0, 3);
    halted = 1'b1;
    checkOutput("glitch_inDone", done, 1'b1);
    tick(1);
    halted = 1'b0;
    checkOutput("glitch_holdDone", done, 1'b1);
    tick(1);
    checkOutput("glitch_left", done, 1'b0);
    sawActivity = 1'b0;
    repeat (20) begin
      tick(1);
      if (out_valid || busy) sawActivity = 1'b1;
    end
    checkOutput("glitch_noFrame", sawActivity, 1'b0);

    // Retrigger with new registers; a change after the trigger is not sent
    $display("[TB] retrigger");
    applyStimulus(8'h10);
    buildExpected(8'h00, 16);
    halted = 1'b1;
    tick(1);
    applyStimulus(8'h80);
    collectFrame(1'b0, 26, 1'b0, 0);
    compareFrame("retrig");
    checkOutput("retrig_regA", gotByteAt(1), 8'h10);
    checkOutput("retrig_chk", gotByteAt(25), 8'hC6);
    halted = 1'b0;
    tick(2);

    // Reset during MEM_WAIT aborts the frame, then a fresh frame follows
    $display("[TB] reset mid-frame");
    applyStimulus(8'h01);
    halted = 1'b1;
    tick(11);
    checkOutput("mw_busy", busy, 1'b1);
    checkOutput("mw_data", out_data, 8'h08);
    #2 reset = 1'b1;
    #1;
    checkOutput("mw_rstValid", out_valid, 1'b0);
    checkOutput("mw_rstData", out_data, 8'h00);
    checkOutput("mw_rstBusy", busy, 1'b0);
    checkOutput("mw_rstMemrd", mem_rd, 1'b0);
    checkOutput("mw_rstAddr", mem_addr, 8'h00);
    halted = 1'b0;
    tick(1);
    reset = 1'b0;
    tick(2);
    buildExpected(8'h00, 16);
    p = cyc;
    halted = 1'b1;
    collectFrame(1'b0, 26, 1'b0, 0);
    compareFrame("fresh");
    checkOutput("fresh_hdrCycle", gotCycleAt(0), p + 1);
    checkOutput("fresh_done", done, 1'b1);

    // halted already high at reset release triggers on the first clock
    $display("[TB] halted high at reset release");
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(1);
    checkOutput("rel_valid", out_valid, 1'b1);
    checkOutput("rel_hdr", out_data, 8'hA5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
